ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 8, RAM address width.
  DATA_W, 8, RAM data width.
REQ-002 Ports SHALL be, clock and reset first, one per line:
  clk  in  1  system clock, all state updates on its rising edge.
  reset  in  1  asynchronous, active-high reset.
  req  in  2  access request per requester; bit 0 is the CPU, bit 1 is the loader/DMA.
  we  in  2  per-requester write enable, qualified by req.
  addr  in  2xADDR_W  per-requester address, packed with requester 0 in the low bits.
  wdata  in  2xDATA_W  per-requester write data, packed with requester 0 in the low bits.
  ack  out  2  one-cycle completion pulse to the winning requester.
  rdata  out  DATA_W  read data, valid while ack is high.
  busy  out  1  high whenever the state is not IDLE.
  ram_addr  out  ADDR_W  address to the single-port RAM.
  ram_wdata  out  DATA_W  write data to the RAM.
  ram_we  out  1  RAM write strobe.
  ram_rdata  in  DATA_W  RAM read data, registered inside the RAM (1-cycle latency).

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-004 IDLE: if any req bit is high, the block SHALL pick one winner and latch its addr, wdata and we, then go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-005 ACCESS SHALL drive ram_addr and ram_wdata from the latched values for exactly one cycle; ram_we SHALL be high in that cycle only if the latched we = 1. The next state SHALL be RESP.
REQ-006 RESP SHALL assert ack[winner] for exactly one cycle, with rdata = ram_rdata captured from the ACCESS read. The next state SHALL be IDLE, unconditionally.
REQ-007 Latency SHALL be: request sampled at edge N, RAM access in cycle N..N+1, ack high in cycle N+1..N+2. This gives 1 access per 3 cycles.
REQ-008 Requesters SHALL hold req, we, addr and wdata stable until ack. A request still high at the edge that ends RESP SHALL be treated as a new request.
REQ-009 Inputs from the non-winning requester SHALL be ignored until the next IDLE arbitration.
REQ-010 Outside ACCESS, ram_we SHALL be 0, and ram_addr and ram_wdata SHALL hold their last values.
REQ-011 On a write, rdata SHALL be the RAM's read-during-write output; requesters SHALL ignore rdata on writes.
REQ-012 Dropping req mid-transaction SHALL NOT abort the transaction; ack is still issued.

Reset
REQ-013 Asserting reset SHALL asynchronously force: state = IDLE, ack = 0, ram_we = 0, busy = 0, rdata = 0, ram_addr = 0, ram_wdata = 0, and the last-winner register = 1 (so the CPU wins the first tie).
REQ-014 Reset asserted during ACCESS SHALL kill ram_we immediately. No ack SHALL follow, and requesters SHALL re-request.

Configuration
REQ-015 With the macro RAM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, the requester that did not win last SHALL win, and the last-winner register SHALL update in IDLE on each grant.
REQ-016 Without RAM_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 (CPU) SHALL always win a tie, and no last-winner register SHALL be synthesized.

Structure
REQ-017 A shared package ram_arb_pkg SHALL hold:
  - the state enum (IDLE, ACCESS, RESP);
  - requester index constants REQ_CPU = 0 and REQ_DMA = 1;
  - the default widths.
REQ-018 One combinational sub-module, ram_arb_pick, SHALL compute the winner from req and the last winner. ram_arbiter SHALL contain the FSM and the registers.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - CPU alone writes 0x5A to address 0x10, then reads 0x10 -> ram_we high for one cycle with ram_addr = 0x10; the read gives ack[0] with rdata = 0x5A, 2 cycles after the request edge.
  - CPU and DMA request on the same edge, both held, with RAM_ARB_RR_EN defined -> grants alternate CPU, DMA, CPU, DMA; each ack arrives 3 cycles after the previous one.
  - Same stimulus without RAM_ARB_RR_EN -> CPU acked every 3 cycles, DMA never acked while the CPU holds req.
  - DMA writes 0xFF to 0x20 while the CPU changes addr mid-transaction -> RAM sees only 0x20; ack[1] only; ack[0] never set.
  - Reset asserted in the ACCESS cycle of a write 0x33 to address 0x40 -> ram_we falls immediately, mem[0x40] unchanged, no ack, busy = 0, state = IDLE.
  - No requests for 20 cycles -> busy = 0, ack = 0, ram_we = 0 throughout.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_arb_pkg
// Shared FSM states, requester indices and default widths for the RAM arbiter.
// Rev    : 1.0
// ============================================================================
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int REQ_CPU    = 0;
    localparam int REQ_DMA    = 1;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : ram_arb_pick
// Combinational winner select: fixed CPU priority, or round-robin on a tie
// when RAM_ARB_RR_EN is defined.
// Rev    : 1.0
// ============================================================================
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef RAM_ARB_RR_EN
    input  logic       last_winner,
`endif
    output logic       winner
);

    always_comb begin
        winner = 1'(REQ_CPU);
        if (req[REQ_DMA] && !req[REQ_CPU]) begin
            winner = 1'(REQ_DMA);
        end
`ifdef RAM_ARB_RR_EN
        else if (req[REQ_DMA] && req[REQ_CPU]) begin
            // On a tie the requester that lost last time goes first.
            winner = ~last_winner;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_arbiter
// Two-requester arbiter for a single-port RAM, one access per three cycles.
// Optional round-robin arbitration: define RAM_ARB_RR_EN.
// Rev    : 1.0
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_rdata
);

    state_t              r_state;
    state_t              w_next;
    logic                w_grant;
    logic                w_winner;
    logic                r_winner;
    logic                r_we;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    ram_arb_pick u_pick (
        .req         (req),
`ifdef RAM_ARB_RR_EN
        .last_winner (r_winner),
`endif
        .winner      (w_winner)
    );

    assign w_sel_addr  = w_winner ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
    assign w_sel_wdata = w_winner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ram_addr/ram_wdata double as the latched request so they hold between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_winner  <= 1'b1;
            r_we      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_grant) begin
                r_winner  <= w_winner;
                r_we      <= we[w_winner];
                ram_addr  <= w_sel_addr;
                ram_wdata <= w_sel_wdata;
            end
            if (r_state == RESP) begin
                r_rdata <= ram_rdata;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        ack     = 2'b00;
        ram_we  = 1'b0;
        rdata   = r_rdata;
        busy    = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_grant = 1'b1;
                    w_next  = ACCESS;
                end
            end
            ACCESS: begin
                ram_we = r_we;
                w_next = RESP;
            end
            RESP: begin
                ack[r_winner] = 1'b1;
                rdata         = ram_rdata;
                w_next        = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_arbiter
// Directed scoreboard bench for ram_arbiter with a registered-read RAM model.
// Rev    : 1.0
// ============================================================================
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read, write-first on read-during-write, bench preload port.
    logic [7:0] mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
    end

    typedef struct {
        int         idx;
        bit         chk;
        logic [7:0] rd;
        int         at;
    } ack_exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         at;
    } wr_exp_t;

    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];
    ack_exp_t e_ack;
    wr_exp_t  e_wr;

    task automatic push_ack(input int idx, input bit chk, input logic [7:0] rd, input int at);
        ack_exp_t e;
        e.idx = idx; e.chk = chk; e.rd = rd; e.at = at;
        ack_q.push_back(e);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input int at);
        wr_exp_t e;
        e.a = a; e.d = d; e.at = at;
        wr_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Monitor: every ack cycle and every RAM write strobe must match the next expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (ack != 2'b00) begin
                n_checks++;
                if (ack_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: ack=%b rdata=%h cyc=%0d, none expected", ack, rdata, cyc);
                end else begin
                    e_ack = ack_q.pop_front();
                    if (ack != 2'(1 << e_ack.idx) || cyc != e_ack.at || (e_ack.chk && rdata != e_ack.rd)) begin
                        n_fail++;
                        $display("FAIL ack_resp: ack=%b rdata=%h cyc=%0d, expected ack=%b rdata=%h cyc=%0d",
                                 ack, rdata, cyc, 2'(1 << e_ack.idx), e_ack.rd, e_ack.at);
                    end
                end
            end
            if (ram_we) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%h data=%h cyc=%0d, none expected", ram_addr, ram_wdata, cyc);
                end else begin
                    e_wr = wr_q.pop_front();
                    if (ram_addr != e_wr.a || ram_wdata != e_wr.d || cyc != e_wr.at) begin
                        n_fail++;
                        $display("FAIL ram_write: addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                                 ram_addr, ram_wdata, cyc, e_wr.a, e_wr.d, e_wr.at);
                    end
                end
            end
        end
    end

    initial begin
        int k;
        int w;

        reset = 1'b1;
        preload(8'h30, 8'hC3);
        preload(8'h40, 8'h77);
        #1;
        check("rst_ack",       32'(ack),       32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_ram_we",    32'(ram_we),    32'h0);
        check("rst_ram_addr",  32'(ram_addr),  32'h0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        check("rst_rdata",     32'(rdata),     32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // CPU write 0x5A to 0x10, then read it back.
        @(posedge clk); #1;
        k = cyc;
        req = 2'b01; we = 2'b01; addr = {8'h00, 8'h10}; wdata = {8'h00, 8'h5A};
        push_wr(8'h10, 8'h5A, k + 1);
        push_ack(0, 1'b0, 8'h00, k + 2);
        repeat (2) @(posedge clk); #1;
        req = 2'b00; we = 2'b00;
        @(posedge clk); #1;
        k = cyc;
        req = 2'b01; addr = {8'h00, 8'h10};
        push_ack(0, 1'b1, 8'h5A, k + 2);
        repeat (2) @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;

        // Both requesters tie and hold; reset first so the last-winner starts at DMA.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        k = cyc;
        req = 2'b11; we = 2'b00; addr = {8'h30, 8'h10};
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_RR_EN
            w = i % 2;
`else
            w = 0;
`endif
            push_ack(w, 1'b1, (w == 1) ? 8'hC3 : 8'h5A, k + 2 + 3 * i);
        end
        repeat (11) @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;

        // DMA write 0xFF to 0x20 while the idle CPU keeps changing its address.
        k = cyc;
        req = 2'b10; we = 2'b11; addr = {8'h20, 8'h00}; wdata = {8'hFF, 8'h11};
        push_wr(8'h20, 8'hFF, k + 1);
        push_ack(1, 1'b0, 8'h00, k + 2);
        repeat (2) begin
            @(posedge clk); #1;
            addr[7:0] = addr[7:0] + 8'h05;
        end
        req = 2'b00; we = 2'b00;
        @(posedge clk); #1;

        // DMA read of 0x20 with req dropped during ACCESS still completes.
        k = cyc;
        req = 2'b10; addr = {8'h20, 8'h0F};
        push_ack(1, 1'b1, 8'hFF, k + 2);
        @(posedge clk); #1;
        req = 2'b00;
        repeat (2) @(posedge clk); #1;
        check("mem_20", 32'(mem[8'h20]), 32'hFF);

        // Reset during the ACCESS cycle of a CPU write 0x33 to 0x40.
        req = 2'b01; we = 2'b01; addr = {8'h00, 8'h40}; wdata = {8'h00, 8'h33};
        @(posedge clk); #1;
        check("access_ram_we", 32'(ram_we), 32'h1);
        check("access_busy",   32'(busy),   32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("kill_ram_we", 32'(ram_we), 32'h0);
        check("kill_busy",   32'(busy),   32'h0);
        check("kill_ack",    32'(ack),    32'h0);
        req = 2'b00; we = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("mem_40_kept", 32'(mem[8'h40]), 32'h77);
        check("post_kill_busy", 32'(busy), 32'h0);

        // Twenty idle cycles.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_busy",   32'(busy),   32'h0);
            check("idle_ack",    32'(ack),    32'h0);
            check("idle_ram_we", 32'(ram_we), 32'h0);
        end

        @(posedge clk); #1;
        check("acks_outstanding",   32'(ack_q.size()), 32'h0);
        check("writes_outstanding", 32'(wr_q.size()),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
